// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider FSM encoding, divide-by-zero quotient.
// Latency: none (declarations only).
// Backpressure: none.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  // Divider FSM state, 2-bit encoding kept as plain constants for legacy tools.
  typedef logic [1:0] div_state_t;
  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t RUN  = 2'd1;
  localparam div_state_t DONE = 2'd2;

  // Divide by zero returns an all-ones quotient; replicate this bit to WIDTH.
  localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/div_trial_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
// Latency: combinational.
// Backpressure: none.
module div_trial_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH:0]   r_shifted,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // Subtract in WIDTH+1 bits so the MSB is the borrow; keep the old value when it borrowed.
  always_comb begin
    trial  = r_shifted - {1'b0, d};
    q_bit  = ~trial[WIDTH];
    r_next = q_bit ? trial : r_shifted;
  end

endmodule

// File: rtl/divider_restoring_eight_bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done in the cycle after WIDTH RUN steps (1 cycle after start for divide by zero).
// Backpressure: ready is low in RUN and DONE; start is ignored there.
module divider_restoring_eight_bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_shifted;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // Shift {R,Q} left by one: the quotient MSB moves into the remainder LSB.
  always_comb begin
    r_shifted = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
    q_next    = {q_reg[WIDTH-2:0], q_bit};
  end

  div_trial_step #(.WIDTH(WIDTH)) u_step (
    .r_shifted (r_shifted),
    .d         (d_reg),
    .r_next    (r_next),
    .q_bit     (q_bit)
  );

  // FSM plus datapath registers; results are published only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              d_reg    <= divisor;
              q_reg    <= dividend;
              r_reg    <= '0;
              cnt      <= '0;
              div_zero <= 1'b0;
              state    <= RUN;
            end else begin
              quotient  <= {WIDTH{DIV_ZERO_Q_BIT}};
              remainder <= dividend;
              div_zero  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_restoring_eight_bit.sv
module tb_divider_restoring_eight_bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t sb[$];
  logic prev_done = 1'b0;

  divider_restoring_eight_bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] n, input logic [W-1:0] d);
    vec_t v;
    v.n = n;
    v.d = d;
    if (d == 0) begin
      v.q  = {W{1'b1}};
      v.r  = n;
      v.dz = 1'b1;
    end else begin
      v.q  = n / d;
      v.r  = n % d;
      v.dz = 1'b0;
    end
    return v;
  endfunction

  // Scoreboard: every done pulse pops one expected result; pulses must be one cycle wide.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("quot %0d/%0d", e.n, e.d), quotient, e.q);
        chk($sformatf("rem %0d/%0d", e.n, e.d), remainder, e.r);
        chk($sformatf("dz %0d/%0d", e.n, e.d), div_zero, e.dz);
      end
    end
    prev_done = rst_n && done;
  end

  // Wait for ready, present one start pulse; returns #1 after the accepting edge.
  task automatic issue(input vec_t v, input bit push);
    int g = 0;
    while (!ready && g < 40) begin
      @(posedge clk); #1; g++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    dividend = v.n;
    divisor  = v.d;
    start    = 1'b1;
    if (push) sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Expect done after exp_lat more edges, with ready low the whole time, then ready again.
  task automatic wait_done(input int exp_lat, input string name);
    int lat = 0;
    int lows = 0;
    while (!done && lat < 30) begin
      if (!ready) lows++;
      @(posedge clk); #1; lat++;
    end
    if (!ready) lows++;
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " ready_low"}, lows, lat + 1);
    @(posedge clk); #1;
    chk({name, " ready_after"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    vec_t tbl[12];
    vec_t v;
    int issued;
    int cyc;
    int g;

    tbl[0]  = '{n: 8'd100, d: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0};
    tbl[1]  = '{n: 8'd255, d: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
    tbl[2]  = '{n: 8'd5,   d: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0};
    tbl[3]  = '{n: 8'd0,   d: 8'd3,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
    tbl[4]  = '{n: 8'd37,  d: 8'd0,   q: 8'd255, r: 8'd37,  dz: 1'b1};
    tbl[5]  = '{n: 8'd8,   d: 8'd2,   q: 8'd4,   r: 8'd0,   dz: 1'b0};
    tbl[6]  = '{n: 8'd255, d: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    tbl[7]  = '{n: 8'd254, d: 8'd255, q: 8'd0,   r: 8'd254, dz: 1'b0};
    tbl[8]  = '{n: 8'd128, d: 8'd16,  q: 8'd8,   r: 8'd0,   dz: 1'b0};
    tbl[9]  = '{n: 8'd7,   d: 8'd2,   q: 8'd3,   r: 8'd1,   dz: 1'b0};
    tbl[10] = '{n: 8'd0,   d: 8'd0,   q: 8'd255, r: 8'd0,   dz: 1'b1};
    tbl[11] = '{n: 8'd201, d: 8'd128, q: 8'd1,   r: 8'd73,  dz: 1'b0};

    // Reset values, checked both during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst quot", quotient, 32'd0);
    chk("rst rem", remainder, 32'd0);
    chk("rst dz", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst ready", {31'd0, ready}, 32'd1);
    chk("post-rst quot", quotient, 32'd0);

    // Directed table: results via scoreboard, timing checked here.
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i], 1'b1);
      wait_done((tbl[i].d == 0) ? 0 : W, $sformatf("vec%0d", i));
    end

    // Start pulsed mid-operation must be ignored; result then held while idle.
    v = '{n: 8'd200, d: 8'd3, q: 8'd66, r: 8'd2, dz: 1'b0};
    issue(v, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dividend = 8'd9;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(W - 3, "ignored_start");
    for (int i = 0; i < 6; i++) begin
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      chk("hold quot", quotient, 32'd66);
      chk("hold rem", remainder, 32'd2);
    end

    // Reset mid-operation: immediate reset state, no done, then a clean rerun.
    v = '{n: 8'd250, d: 8'd7, q: 8'd35, r: 8'd5, dz: 1'b0};
    issue(v, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst ready", {31'd0, ready}, 32'd1);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst quot", quotient, 32'd0);
    chk("midrst rem", remainder, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst no_done", {31'd0, done}, 32'd0);
    end
    issue(v, 1'b1);
    wait_done(W, "after_rst");

    // Random sweep with start held high: a new operation each IDLE cycle.
    start  = 1'b1;
    issued = 0;
    cyc    = 0;
    while (issued < 2500 && cyc < 40000) begin
      if (ready) begin
        v = model(8'($urandom), ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom));
        dividend = v.n;
        divisor  = v.d;
        sb.push_back(v);
        issued++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("sweep issued", issued, 32'd2500);

    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
